c_mat_mult_seq: RTL and testbench
=================================

# c_mat_mult_seq

Sequenced matrix multiplier controller: accepts a pair of bit matrices over a valid/ready handshake and computes their product over a configurable number of cycles. Each cycle it drives a shared row-slice multiply datapath (`rows_per_cycle` rows of A against all of B) and writes the slice into a result register. It presents the completed product over a second valid/ready handshake. It sits between coding/hashing front-ends and consumers that need GF(2) or other `c_binary_op`-style matrix products, and trades area for latency.

## Interface
- `dim1_width`, 1: rows of A and of the result.
- `dim2_width`, 1: columns of A, rows of B.
- `dim3_width`, 1: columns of B and of the result.
- `rows_per_cycle`, 1: result rows computed per COMPUTE cycle; must divide `dim1_width`.
- `prod_op`, `BINARY_OP_AND`: element product operator.
- `sum_op`, `BINARY_OP_XOR`: reduction operator.
- `clk`  input  1  clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands.
- `input_a`  input  `[0:dim1_width*dim2_width-1]`  matrix A, row-major.
- `input_b`  input  `[0:dim2_width*dim3_width-1]`  matrix B, row-major.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer takes the result.
- `result`  output  `[0:dim1_width*dim3_width-1]`  product, row-major, registered.
- `busy`  output  1  state is not IDLE.

## Operation
- S = `dim1_width/rows_per_cycle` steps. Step counter width = max(1, clog2(S)).
- States: IDLE, COMPUTE, DONE.
- IDLE: `in_ready`=1. On `in_valid&in_ready`:
  - latch A and B into operand registers;
  - clear the result register to 0;
  - step←0;
  - go to COMPUTE.
- COMPUTE: each cycle the datapath evaluates rows [step*rows_per_cycle, +rows_per_cycle) from the latched operands and writes them into the result register.
  - If step==S-1: go to DONE.
  - Otherwise: step←step+1.
  - Inputs are ignored and `in_ready`=0.
- DONE: `out_valid`=1 and `result` is held stable.
  - On `out_ready`: output handshake completes.
  - `in_ready`=`out_ready`. A simultaneous output and input handshake loads the new operands and goes straight to COMPUTE, with no IDLE bubble.
  - Output handshake only: go to IDLE.
- Element (r,c) = `sum_op` over k of `prod_op`(A[r][k], B[k][c]), identical to the combinational product.
- Operands changing while not in IDLE, or in DONE without an input handshake, have no effect.

## Timing
- Reset values:
  - state=IDLE, step=0, operand registers=0, result=0;
  - `in_ready`=1, `out_valid`=0, `busy`=0.
- Reset assertion mid-COMPUTE or in DONE aborts immediately; the partial or finished result is discarded (reads 0).
- Latency: with acceptance at edge t, `out_valid` rises after edge t+S. With S=1 it rises one cycle after acceptance.
- Throughput with `out_ready` held 1: one product per S+1 cycles. Back-to-back DONE→COMPUTE gives S+1; the DONE cycle itself is not skipped.
- `in_ready` and `out_valid` are functions of state plus `out_ready` only. There is no combinational path from `in_valid` to any output.

## Configuration
- `C_MAT_MULT_SEQ_ABORT_EN` defined:
  - adds input `abort` (1 bit, synchronous);
  - when `abort`=1 in COMPUTE or DONE: state←IDLE, result←0, `out_valid` deasserts next cycle;
  - abort has priority over every handshake in the same cycle;
  - in IDLE, abort has no effect and also blocks acceptance that cycle.
- Not defined: the port is absent; a sequence always runs to completion.

## Structure
- State encoding (IDLE/COMPUTE/DONE localparams) and the `BINARY_OP_*` codes come from the shared `c_constants` include. `clog2` comes from the shared functions include.
- One sub-module: existing `c_mat_mult`, instantiated with dim1_width=`rows_per_cycle`. Its A input is fed by a row-slice mux of the latched A, selected by step.
- Controller logic (FSM, counter, result write-enable decode) stays in this module.

## Test plan
- Identity, 4x4x4, rows_per_cycle=1:
  - A=identity (0x8421 row-major), B=0x1234 -> `out_valid` 4 cycles after accept, result=0x1234.
- Dense, 2x3x2, rows_per_cycle=2 (S=1):
  - A=0b111_101, B=0b10_01_11 -> result=0b00_01, `out_valid` 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `result` stable, `in_ready`=0, `out_valid`=1; then `out_ready`=1 -> IDLE next cycle.
- Back-to-back: `in_valid`=`out_ready`=1 continuously, S=4 -> new output every 5 cycles, and each result matches the golden model.
- Reset mid-COMPUTE at step 2: assert `reset_n`=0 -> outputs immediately at reset values; after release, accept a new pair and produce the correct result.
- With `C_MAT_MULT_SEQ_ABORT_EN`: `abort` at step 1 with `in_valid`=1 -> IDLE, result=0, no `out_valid`, no acceptance that cycle.

Source files
------------

// File: rtl/c_mat_mult_seq_pkg.sv
// Shared types and helpers for the sequenced matrix multiplier: element operator codes,
// controller state encoding, clog2 and the single-bit binary operator.
package c_mat_mult_seq_pkg;

  localparam int unsigned BINARY_OP_AND  = 0;
  localparam int unsigned BINARY_OP_NAND = 1;
  localparam int unsigned BINARY_OP_OR   = 2;
  localparam int unsigned BINARY_OP_NOR  = 3;
  localparam int unsigned BINARY_OP_XOR  = 4;
  localparam int unsigned BINARY_OP_XNOR = 5;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_COMPUTE = 2'd1,
    STATE_DONE    = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

  function automatic logic binary_op(input int unsigned op, input logic a, input logic b);
    case (op)
      BINARY_OP_AND:  return a & b;
      BINARY_OP_NAND: return ~(a & b);
      BINARY_OP_OR:   return a | b;
      BINARY_OP_NOR:  return ~(a | b);
      BINARY_OP_XOR:  return a ^ b;
      BINARY_OP_XNOR: return ~(a ^ b);
      default:        return a & b;
    endcase
  endfunction

endpackage

// File: rtl/c_mat_mult_seq_mult.sv
// Combinational bit-matrix product: element (r,c) is the sum_op reduction over k
// of prod_op(A[r][k], B[k][c]); vectors are row-major with element 0 at index 0.
module c_mat_mult_seq_mult
  import c_mat_mult_seq_pkg::*;
#(
  parameter int unsigned dim1_width = 1,
  parameter int unsigned dim2_width = 1,
  parameter int unsigned dim3_width = 1,
  parameter int unsigned prod_op    = BINARY_OP_AND,
  parameter int unsigned sum_op     = BINARY_OP_XOR
) (
  input  logic [0:dim1_width*dim2_width-1] input_a,
  input  logic [0:dim2_width*dim3_width-1] input_b,
  output logic [0:dim1_width*dim3_width-1] result
);

  logic acc;

  always_comb begin
    result = '0;
    acc    = 1'b0;
    for (int unsigned r = 0; r < dim1_width; r++) begin
      for (int unsigned c = 0; c < dim3_width; c++) begin
        acc = binary_op(prod_op, input_a[r*dim2_width], input_b[c]);
        for (int unsigned k = 1; k < dim2_width; k++) begin
          acc = binary_op(sum_op, acc,
                          binary_op(prod_op, input_a[r*dim2_width+k], input_b[k*dim3_width+c]));
        end
        result[r*dim3_width+c] = acc;
      end
    end
  end

endmodule

// File: rtl/c_mat_mult_seq.sv
// Sequenced matrix multiplier: computes rows_per_cycle result rows per cycle through a
// shared row-slice datapath. Optional synchronous abort port via C_MAT_MULT_SEQ_ABORT_EN.
module c_mat_mult_seq
  import c_mat_mult_seq_pkg::*;
#(
  parameter int unsigned dim1_width     = 1,
  parameter int unsigned dim2_width     = 1,
  parameter int unsigned dim3_width     = 1,
  parameter int unsigned rows_per_cycle = 1,
  parameter int unsigned prod_op        = BINARY_OP_AND,
  parameter int unsigned sum_op         = BINARY_OP_XOR
) (
  input  logic                             clk,
  input  logic                             reset_n,
`ifdef C_MAT_MULT_SEQ_ABORT_EN
  input  logic                             abort,
`endif
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [0:dim1_width*dim2_width-1] input_a,
  input  logic [0:dim2_width*dim3_width-1] input_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [0:dim1_width*dim3_width-1] result,
  output logic                             busy
);

  localparam int unsigned NUM_STEPS = dim1_width / rows_per_cycle;
  localparam int unsigned STEP_W    = (clog2(NUM_STEPS) > 0) ? clog2(NUM_STEPS) : 1;
  localparam int unsigned A_W       = dim1_width * dim2_width;
  localparam int unsigned B_W       = dim2_width * dim3_width;
  localparam int unsigned A_SLICE_W = rows_per_cycle * dim2_width;
  localparam int unsigned R_SLICE_W = rows_per_cycle * dim3_width;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  state_t                state, state_nxt;
  logic [STEP_W-1:0]     step;
  logic [0:A_W-1]        a_reg;
  logic [0:B_W-1]        b_reg;
  logic [0:A_SLICE_W-1]  a_slice;
  logic [0:R_SLICE_W-1]  slice_result;
  logic                  load;
  logic                  clear;
  logic                  res_we;
  logic                  abort_hit;

`ifdef C_MAT_MULT_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Rows of A for the current step feed the shared datapath
  assign a_slice = a_reg[32'(step)*A_SLICE_W +: A_SLICE_W];

  c_mat_mult_seq_mult #(
    .dim1_width (rows_per_cycle),
    .dim2_width (dim2_width),
    .dim3_width (dim3_width),
    .prod_op    (prod_op),
    .sum_op     (sum_op)
  ) u_mult (
    .input_a (a_slice),
    .input_b (b_reg),
    .result  (slice_result)
  );

  // Next state, handshake decode and result write enable
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    res_we    = 1'b0;
    case (state)
      STATE_IDLE: begin
        in_ready = ~abort_hit;
        if (in_valid && !abort_hit) begin
          load      = 1'b1;
          state_nxt = STATE_COMPUTE;
        end
      end
      STATE_COMPUTE: begin
        if (abort_hit) begin
          clear     = 1'b1;
          state_nxt = STATE_IDLE;
        end else begin
          res_we = 1'b1;
          if (step == STEP_LAST) state_nxt = STATE_DONE;
        end
      end
      STATE_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~abort_hit;
        if (abort_hit) begin
          clear     = 1'b1;
          state_nxt = STATE_IDLE;
        end else if (out_ready) begin
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = STATE_COMPUTE;
          end else begin
            state_nxt = STATE_IDLE;
          end
        end
      end
      default: state_nxt = STATE_IDLE;
    endcase
  end

  assign busy = (state != STATE_IDLE);

  // State, step counter, operand and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= STATE_IDLE;
      step   <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_reg  <= input_a;
        b_reg  <= input_b;
        result <= '0;
        step   <= '0;
      end else if (clear) begin
        result <= '0;
        step   <= '0;
      end else if (res_we) begin
        result[32'(step)*R_SLICE_W +: R_SLICE_W] <= slice_result;
        if (step != STEP_LAST) step <= step + STEP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_c_mat_mult_seq.sv
// Scoreboard bench for c_mat_mult_seq: a 4x4x4 one-row-per-cycle instance and a
// 2x3x2 single-step instance, with directed hand-computed vectors.
module tb_c_mat_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Instance A: 4x4x4, rows_per_cycle=1 (4 steps)
  logic        iv_a, ir_a, ov_a, or_a, busy_a, abort_a;
  logic [0:15] ina_a, inb_a, res_a;
  // Instance B: 2x3x2, rows_per_cycle=2 (1 step)
  logic        iv_b, ir_b, ov_b, or_b, busy_b, abort_b;
  logic [0:5]  ina_b, inb_b;
  logic [0:3]  res_b;

  c_mat_mult_seq #(
    .dim1_width(4), .dim2_width(4), .dim3_width(4), .rows_per_cycle(1)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_n),
`ifdef C_MAT_MULT_SEQ_ABORT_EN
    .abort(abort_a),
`endif
    .in_valid(iv_a), .in_ready(ir_a), .input_a(ina_a), .input_b(inb_a),
    .out_valid(ov_a), .out_ready(or_a), .result(res_a), .busy(busy_a)
  );

  c_mat_mult_seq #(
    .dim1_width(2), .dim2_width(3), .dim3_width(2), .rows_per_cycle(2)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_n),
`ifdef C_MAT_MULT_SEQ_ABORT_EN
    .abort(abort_b),
`endif
    .in_valid(iv_b), .in_ready(ir_b), .input_a(ina_b), .input_b(inb_b),
    .out_valid(ov_b), .out_ready(or_b), .result(res_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_a[$], exp_b[$];
  int          acc_a[$], acc_b[$], hs_a[$];
  logic        prev_ov_a = 1'b0, prev_ov_b = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor A: latency on out_valid rise, result on output handshake
  always @(negedge clk) begin
    if (!rst_n) prev_ov_a = 1'b0;
    else begin
      if (ov_a && !prev_ov_a) begin
        if (acc_a.size() == 0) fail_now("unexpected_out_valid_a");
        else chk("latency_a", 16'(cyc - acc_a.pop_front()), 16'd4);
      end
      if (ov_a && or_a) begin
        hs_a.push_back(cyc + 1);
        if (exp_a.size() == 0) fail_now("unexpected_result_a");
        else chk("result_a", res_a, exp_a.pop_front());
      end
      if (iv_a && ir_a) acc_a.push_back(cyc + 1);
      prev_ov_a = ov_a;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst_n) prev_ov_b = 1'b0;
    else begin
      if (ov_b && !prev_ov_b) begin
        if (acc_b.size() == 0) fail_now("unexpected_out_valid_b");
        else chk("latency_b", 16'(cyc - acc_b.pop_front()), 16'd1);
      end
      if (ov_b && or_b) begin
        if (exp_b.size() == 0) fail_now("unexpected_result_b");
        else chk("result_b", 16'(res_b), exp_b.pop_front());
      end
      if (iv_b && ir_b) acc_b.push_back(cyc + 1);
      prev_ov_b = ov_b;
    end
  end

  // Present a pair on A and wait for its acceptance; in_valid is left high
  task automatic send_a(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    logic ok;
    int   n;
    ina_a = a;
    inb_a = b;
    iv_a  = 1'b1;
    exp_a.push_back(e);
    n = 0;
    forever begin
      ok = ir_a;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 50) begin fail_now("accept_timeout_a"); break; end
    end
  endtask

  task automatic send_b(input logic [5:0] a, input logic [5:0] b, input logic [3:0] e);
    logic ok;
    int   n;
    ina_b = a;
    inb_b = b;
    iv_b  = 1'b1;
    exp_b.push_back(16'(e));
    n = 0;
    forever begin
      ok = ir_b;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 50) begin fail_now("accept_timeout_b"); break; end
    end
  endtask

  task automatic wait_ov_a();
    int n = 0;
    while (!ov_a && n < 40) begin @(posedge clk); #1; n++; end
    if (!ov_a) fail_now("out_valid_timeout_a");
  endtask

  task automatic wait_ov_b();
    int n = 0;
    while (!ov_b && n < 40) begin @(posedge clk); #1; n++; end
    if (!ov_b) fail_now("out_valid_timeout_b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct { logic [15:0] a, b, e; } vec_t;
  vec_t b2b[4];

  initial begin
    rst_n = 1'b0;
    iv_a = 0; or_a = 0; abort_a = 0; ina_a = '0; inb_a = '0;
    iv_b = 0; or_b = 0; abort_b = 0; ina_b = '0; inb_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_a", 16'(ir_a), 16'd1);
    chk("rst_out_valid_a", 16'(ov_a), 16'd0);
    chk("rst_busy_a", 16'(busy_a), 16'd0);
    chk("rst_result_a", res_a, 16'h0000);
    chk("rst_in_ready_b", 16'(ir_b), 16'd1);
    chk("rst_result_b", 16'(res_b), 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity times B returns B
    or_a = 1'b1;
    send_a(16'h8421, 16'h1234, 16'h1234);
    iv_a = 1'b0;
    wait_ov_a();
    @(posedge clk); #1;
    chk("idle_after_identity", 16'(busy_a), 16'd0);

    // Dense GF(2) products, single step
    or_b = 1'b1;
    send_b(6'b111_101, 6'b10_01_11, 4'b00_01);
    iv_b = 1'b0;
    wait_ov_b();
    @(posedge clk); #1;
    send_b(6'b110_011, 6'b11_10_01, 4'b01_11);
    iv_b = 1'b0;
    wait_ov_b();
    @(posedge clk); #1;
    chk("idle_after_dense", 16'(busy_b), 16'd0);

    // Backpressure: anti-identity reverses the rows of B
    or_a = 1'b0;
    send_a(16'h1248, 16'hABCD, 16'hDCBA);
    iv_a = 1'b0;
    wait_ov_a();
    for (int i = 0; i < 10; i++) begin
      chk("hold_result", res_a, 16'hDCBA);
      chk("hold_in_ready", 16'(ir_a), 16'd0);
      chk("hold_out_valid", 16'(ov_a), 16'd1);
      @(posedge clk); #1;
    end
    or_a = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_backpressure", 16'(busy_a), 16'd0);

    // Back-to-back with in_valid and out_ready held high
    b2b[0] = '{16'h8421, 16'hBEEF, 16'hBEEF};
    b2b[1] = '{16'hFFFF, 16'h1234, 16'h4444};
    b2b[2] = '{16'h1248, 16'hABCD, 16'hDCBA};
    b2b[3] = '{16'h0000, 16'hFFFF, 16'h0000};
    hs_a.delete();
    for (int i = 0; i < 4; i++) send_a(b2b[i].a, b2b[i].b, b2b[i].e);
    iv_a = 1'b0;
    for (int n = 0; n < 60 && hs_a.size() < 4; n++) begin @(posedge clk); #1; end
    if (hs_a.size() < 4) fail_now("b2b_handshake_timeout");
    else for (int i = 1; i < 4; i++) chk("b2b_interval", 16'(hs_a[i] - hs_a[i-1]), 16'd5);
    @(posedge clk); #1;

    // Reset while at step 2 discards the computation
    send_a(16'h8421, 16'hF0F0, 16'hF0F0);
    iv_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy_a), 16'd0);
    chk("midrst_in_ready", 16'(ir_a), 16'd1);
    chk("midrst_out_valid", 16'(ov_a), 16'd0);
    chk("midrst_result", res_a, 16'h0000);
    exp_a.delete();
    acc_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(16'hFFFF, 16'h1234, 16'h4444);
    iv_a = 1'b0;
    wait_ov_a();
    @(posedge clk); #1;

`ifdef C_MAT_MULT_SEQ_ABORT_EN
    // Abort at step 1 with a new pair presented
    send_a(16'h8421, 16'h1234, 16'h1234);
    @(posedge clk); #1;
    ina_a   = 16'hFFFF;
    abort_a = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 16'(busy_a), 16'd0);
    chk("abort_result", res_a, 16'h0000);
    chk("abort_out_valid", 16'(ov_a), 16'd0);
    chk("abort_blocks_ready", 16'(ir_a), 16'd0);
    @(posedge clk); #1;
    chk("abort_no_accept", 16'(busy_a), 16'd0);
    abort_a = 1'b0;
    iv_a    = 1'b0;
    exp_a.delete();
    acc_a.delete();
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("drained_a", 16'(exp_a.size()), 16'd0);
    chk("drained_b", 16'(exp_b.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
